// File: rtl/median_window_fifo_if.sv
// Handshake/bus bundle for median_window_fifo.
// Optional ports (occupancy, overrun_err) exist only when MEDIAN_FIFO_OCCUPANCY_EN is defined.
interface median_window_fifo_if #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned LOG_WMAX    = 4
);
    logic                   flush;
    logic [LOG_WMAX:0]      W;
    logic                   in_valid;
    logic [DATA_LENGTH-1:0] X;
    logic [DATA_LENGTH-1:0] R_old;
    logic                   old_valid;
    logic                   window_full;
    logic [1:0]             state;
`ifdef MEDIAN_FIFO_OCCUPANCY_EN
    logic [LOG_WMAX:0]      occupancy;
    logic                   overrun_err;
`endif

`ifdef MEDIAN_FIFO_OCCUPANCY_EN
    modport master (
        output flush, W, in_valid, X,
        input  R_old, old_valid, window_full, state, occupancy, overrun_err
    );
    modport slave (
        input  flush, W, in_valid, X,
        output R_old, old_valid, window_full, state, occupancy, overrun_err
    );
`else
    modport master (
        output flush, W, in_valid, X,
        input  R_old, old_valid, window_full, state
    );
    modport slave (
        input  flush, W, in_valid, X,
        output R_old, old_valid, window_full, state
    );
`endif
endinterface

// File: rtl/median_window_fifo.sv
// Sample-history buffer for the FIFO median array: stores every sample and presents the one
// leaving the window (R_old) combinationally alongside the new X.
// Optional feature macro: MEDIAN_FIFO_OCCUPANCY_EN (adds occupancy and overrun_err outputs).
module median_window_fifo #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned WMAX        = 16,
    parameter int unsigned LOG_WMAX    = 4
) (
    input logic                 clk,
    input logic                 reset,
    median_window_fifo_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StFill = 2'b01,
        StRun  = 2'b10
    } state_e;

    localparam logic [LOG_WMAX:0]   WmaxW  = (LOG_WMAX + 1)'(WMAX);
    localparam logic [LOG_WMAX:0]   OneW   = (LOG_WMAX + 1)'(1);
    localparam logic [LOG_WMAX-1:0] WpLast = LOG_WMAX'(WMAX - 1);

    state_e                 state_q, state_d;
    logic [LOG_WMAX-1:0]    wp_q, wp_d;
    logic [LOG_WMAX:0]      count_q, count_d;
    logic [LOG_WMAX:0]      w_q, w_d;
    logic                   window_full_q, window_full_d;
    logic                   latch_q, latch_d;  // W still to be sampled after reset release
    logic [DATA_LENGTH-1:0] mem [WMAX];

    logic [LOG_WMAX:0]      w_clamped;
    logic [LOG_WMAX:0]      w_eff;
    logic [LOG_WMAX:0]      wp_ext;
    logic [LOG_WMAX:0]      rd_full;
    logic [LOG_WMAX-1:0]    rd_idx;
    logic                   old_valid;

    // Clamp the requested window into 1..WMAX
    always_comb begin
        if (bus.W == '0) begin
            w_clamped = OneW;
        end else if (bus.W > WmaxW) begin
            w_clamped = WmaxW;
        end else begin
            w_clamped = bus.W;
        end
    end

    // Read index of the expiring sample; explicit wrap so WMAX need not be a power of two
    always_comb begin
        wp_ext = {1'b0, wp_q};
        if (wp_ext >= w_q) begin
            rd_full = wp_ext - w_q;
        end else begin
            rd_full = wp_ext + WmaxW - w_q;
        end
        rd_idx = LOG_WMAX'(rd_full);
    end

    // Expiring-sample outputs, forced to zero when not retiring
    always_comb begin
        old_valid     = (state_q == StRun) && bus.in_valid;
        bus.old_valid = old_valid;
        bus.R_old     = old_valid ? mem[rd_idx] : '0;
    end

    // Next-state logic: flush beats in_valid; first edge after reset latches W
    always_comb begin
        state_d       = state_q;
        wp_d          = wp_q;
        count_d       = count_q;
        w_d           = w_q;
        window_full_d = window_full_q;
        latch_d       = 1'b0;
        w_eff         = latch_q ? w_clamped : w_q;
        if (latch_q) begin
            w_d = w_clamped;
        end
        if (bus.flush) begin
            state_d       = StIdle;
            wp_d          = '0;
            count_d       = '0;
            window_full_d = 1'b0;
            w_d           = w_clamped;
        end else if (bus.in_valid) begin
            wp_d = (wp_q == WpLast) ? '0 : wp_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    count_d = OneW;
                    if (w_eff == OneW) begin
                        state_d       = StRun;
                        window_full_d = 1'b1;
                    end else begin
                        state_d = StFill;
                    end
                end
                StFill: begin
                    count_d = count_q + 1'b1;
                    if ((count_q + 1'b1) == w_eff) begin
                        state_d       = StRun;
                        window_full_d = 1'b1;
                    end
                end
                StRun: begin
                    count_d = count_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            wp_q          <= '0;
            count_q       <= '0;
            w_q           <= WmaxW;
            window_full_q <= 1'b0;
            latch_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            wp_q          <= wp_d;
            count_q       <= count_d;
            w_q           <= w_d;
            window_full_q <= window_full_d;
            latch_q       <= latch_d;
        end
    end

    // Sample storage, not reset; stale entries are masked by old_valid until refilled
    always_ff @(posedge clk) begin
        if (bus.in_valid && !bus.flush) begin
            mem[wp_q] <= bus.X;
        end
    end

    assign bus.window_full = window_full_q;
    assign bus.state       = state_q;

`ifdef MEDIAN_FIFO_OCCUPANCY_EN
    logic overrun_q, overrun_d;

    // Sticky collision flag, cleared only by reset
    always_comb begin
        overrun_d = overrun_q | (bus.flush & bus.in_valid);
    end

    // Overrun register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.occupancy   = count_q;
    assign bus.overrun_err = overrun_q;
`endif
endmodule
